// File: rtl/pll_lock_supervisor_if.sv
// Status/control bundle of the PLL lock supervisor: raw lock in, reset/status out.
interface pll_lock_supervisor_if #(
    parameter int CNT_W = 8
);
    logic             locked;
    logic             loss_clr;
    logic             pll_rst_n;
    logic             ready;
    logic [CNT_W-1:0] loss_count;
    logic [1:0]       state;
    logic             timeout;

    modport master (
        output locked, loss_clr,
        input  pll_rst_n, ready, loss_count, state, timeout
    );

    modport slave (
        input  locked, loss_clr,
        output pll_rst_n, ready, loss_count, state, timeout
    );
endinterface

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor on the 48 MHz reference clock: syncs lock, gates the PLL-domain reset,
// counts lock losses. Define PLL_TIMEOUT_EN to build the sticky lock-acquire timeout.
module pll_lock_supervisor #(
    parameter int STABLE_CYCLES  = 4800,
    parameter int RECOVER_CYCLES = 480,
    parameter int CNT_W          = 8,
    parameter int TIMEOUT_CYCLES = 48000
) (
    input logic                  clock,
    input logic                  reset_n,
    pll_lock_supervisor_if.slave bus
);
    typedef enum logic [1:0] {
        WAIT_LOCK = 2'b00,
        STABILIZE = 2'b01,
        RUN       = 2'b10,
        LOST      = 2'b11
    } state_t;

    localparam int SW = (STABLE_CYCLES  > 1) ? $clog2(STABLE_CYCLES)  : 1;
    localparam int RW = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;
    localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [RW-1:0] REC_LAST  = RW'(RECOVER_CYCLES - 1);

    if (STABLE_CYCLES < 1 || RECOVER_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("pll_lock_supervisor: cycle parameters must be >= 1");
    end

    logic          sync1, lk;
    state_t        st;
    logic [SW-1:0] stab_cnt;
    logic [RW-1:0] rec_cnt;
    logic          loss_evt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            lk    <= 1'b0;
        end else begin
            sync1 <= bus.locked;
            lk    <= sync1;
        end
    end

    // pll_rst_n/ready are set alongside the state transition so all three move on one edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            st            <= WAIT_LOCK;
            stab_cnt      <= '0;
            rec_cnt       <= '0;
            bus.pll_rst_n <= 1'b0;
            bus.ready     <= 1'b0;
        end else begin
            case (st)
                WAIT_LOCK: if (lk) begin
                    st       <= STABILIZE;
                    stab_cnt <= '0;
                end
                STABILIZE: if (!lk) begin
                    st <= WAIT_LOCK;
                end else if (stab_cnt == STAB_LAST) begin
                    st            <= RUN;
                    bus.pll_rst_n <= 1'b1;
                    bus.ready     <= 1'b1;
                end else begin
                    stab_cnt <= stab_cnt + 1'b1;
                end
                RUN: if (!lk) begin
                    st            <= LOST;
                    rec_cnt       <= '0;
                    bus.pll_rst_n <= 1'b0;
                    bus.ready     <= 1'b0;
                end
                LOST: if (rec_cnt == REC_LAST) begin
                    st <= WAIT_LOCK;
                end else begin
                    rec_cnt <= rec_cnt + 1'b1;
                end
                default: begin
                    st            <= WAIT_LOCK;
                    bus.pll_rst_n <= 1'b0;
                    bus.ready     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.state = st;
    assign loss_evt  = (st == RUN) && !lk;

    // A clear in the same cycle as a loss leaves the counter at zero.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus.loss_count <= '0;
        end else if (bus.loss_clr) begin
            bus.loss_count <= '0;
        end else if (loss_evt && (bus.loss_count != {CNT_W{1'b1}})) begin
            bus.loss_count <= bus.loss_count + 1'b1;
        end
    end

`ifdef PLL_TIMEOUT_EN
    localparam int AW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [AW-1:0] ACQ_LAST = AW'(TIMEOUT_CYCLES - 1);
    localparam logic [AW-1:0] ACQ_END  = AW'(TIMEOUT_CYCLES);

    logic [AW-1:0] acq_cnt;
    logic          tout;
    logic          waiting, to_active;

    assign waiting   = (st == WAIT_LOCK) || (st == STABILIZE);
    assign to_active = ((st == STABILIZE) && lk && (stab_cnt == STAB_LAST)) || loss_evt;

    // acq_cnt parks one past the trigger value so a cleared flag is not re-raised while still waiting.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acq_cnt <= '0;
            tout    <= 1'b0;
        end else begin
            if (to_active)
                acq_cnt <= '0;
            else if (waiting && (acq_cnt != ACQ_END))
                acq_cnt <= acq_cnt + 1'b1;

            if (bus.loss_clr)
                tout <= 1'b0;
            else if (waiting && (acq_cnt == ACQ_LAST))
                tout <= 1'b1;
        end
    end

    assign bus.timeout = tout;
`else
    assign bus.timeout = 1'b0;
`endif
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor: per-cycle comparison against a lock-streak model
// plus hand-computed latency/count expectations.
module tb_pll_lock_supervisor;
    localparam int S    = 16;
    localparam int R    = 6;
    localparam int CW   = 8;
    localparam int T    = 100;
    localparam int CMAX = (1 << CW) - 1;

    logic clock   = 1'b0;
    logic reset_n = 1'b1;

    pll_lock_supervisor_if #(.CNT_W(CW)) bus ();

    pll_lock_supervisor #(
        .STABLE_CYCLES (S),
        .RECOVER_CYCLES(R),
        .CNT_W         (CW),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus.slave)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    // Model: lock as seen two edges late, streak of good lock, countdown while lost.
    logic h1 = 1'b0, h2 = 1'b0, m_lk;
    int   m_streak = 0, m_lost_left = 0, m_count = 0, m_wait = 0, m_pre = 0;
    bit   m_run = 1'b0, m_tout = 1'b0, m_loss;

    function automatic int m_state();
        if (m_lost_left > 0) return 3;
        if (m_run)           return 2;
        if (m_streak > 0)    return 1;
        return 0;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            h1 = 1'b0; h2 = 1'b0;
            m_streak = 0; m_lost_left = 0; m_count = 0; m_wait = 0;
            m_run = 1'b0; m_tout = 1'b0;
        end else begin
            m_lk   = h2;
            h2     = h1;
            h1     = bus.locked;
            m_pre  = m_state();
            m_loss = 1'b0;
            if (m_lost_left > 0) begin
                m_lost_left--;
            end else if (m_run) begin
                if (!m_lk) begin
                    m_run = 1'b0; m_lost_left = R; m_loss = 1'b1;
                end
            end else if (m_lk) begin
                m_streak++;
                if (m_streak == S + 1) begin
                    m_run = 1'b1; m_streak = 0;
                end
            end else begin
                m_streak = 0;
            end
            if (bus.loss_clr)                 m_count = 0;
            else if (m_loss && m_count < CMAX) m_count++;
`ifdef PLL_TIMEOUT_EN
            if (m_pre <= 1) m_wait++;
            if (bus.loss_clr)       m_tout = 1'b0;
            else if (m_wait == T)   m_tout = 1'b1;
            if (m_state() >= 2) m_wait = 0;
`endif
        end
    end

    always @(negedge clock) begin
        int es;
        es = m_state();
        tests++;
        if (bus.state !== 2'(es) || bus.pll_rst_n !== (es == 2) || bus.ready !== (es == 2) ||
            bus.loss_count !== CW'(m_count) || bus.timeout !== m_tout) begin
            fails++;
            $display("FAIL model t=%0t: got st=%0d rst_n=%b rdy=%b cnt=%0d to=%b, expected st=%0d rst_n=%b rdy=%b cnt=%0d to=%b",
                     $time, bus.state, bus.pll_rst_n, bus.ready, bus.loss_count, bus.timeout,
                     es, es == 2, es == 2, m_count, m_tout);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_run(output int n);
        n = 0;
        while (bus.pll_rst_n !== 1'b1 && n < 1000) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (n >= 1000) chk("wait_run_budget", n, -1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got time %0t expected under 2000000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int exp_to;
        bus.locked   = 1'b1;
        bus.loss_clr = 1'b0;
        #1 reset_n = 1'b0;
        tick(3);
        chk("reset_rst_n", bus.pll_rst_n, 0);
        chk("reset_ready", bus.ready, 0);
        chk("reset_state", bus.state, 0);
        chk("reset_count", bus.loss_count, 0);
        chk("reset_timeout", bus.timeout, 0);

        // Release with lock already present
        reset_n = 1'b1;
        wait_run(n);
        chk("release_edges", n, S + 3);
        chk("release_state", bus.state, 2);
        chk("release_ready", bus.ready, 1);

        // Lock drop in RUN
        bus.locked = 1'b0;
        tick(2);
        chk("drop_hold", bus.pll_rst_n, 1);
        tick(1);
        chk("drop_rst_n", bus.pll_rst_n, 0);
        chk("drop_state", bus.state, 3);
        chk("drop_count", bus.loss_count, 1);
        tick(R - 1);
        chk("lost_hold", bus.state, 3);
        tick(1);
        chk("lost_exit", bus.state, 0);
        tick(10 - 3 - R);
        bus.locked = 1'b1;
        wait_run(n);
        chk("relock_edges", n, S + 3);

        // Glitch during STABILIZE: back to WAIT_LOCK, no loss, counting restarts
        bus.locked = 1'b0;
        tick(3 + R);
        bus.locked = 1'b1;
        tick(8);
        chk("stab_mid", bus.state, 1);
        bus.locked = 1'b0;
        tick(1);
        bus.locked = 1'b1;
        tick(2);
        chk("glitch_state", bus.state, 0);
        chk("glitch_count", bus.loss_count, 2);
        wait_run(n);
        chk("restab_edges", n, S + 1);

        // 258 more losses -> 260 total, saturating
        for (int i = 0; i < 258; i++) begin
            bus.locked = 1'b0;
            tick(3 + R);
            bus.locked = 1'b1;
            wait_run(n);
        end
        chk("sat_count", bus.loss_count, 255);

        // Clear coinciding with a new loss
        bus.locked = 1'b0;
        tick(2);
        bus.loss_clr = 1'b1;
        tick(1);
        bus.loss_clr = 1'b0;
        chk("clr_vs_loss", bus.loss_count, 0);
        chk("clr_state", bus.state, 3);

        // Long wait with no lock
        tick(R + T + 10);
`ifdef PLL_TIMEOUT_EN
        exp_to = 1;
`else
        exp_to = 0;
`endif
        chk("timeout_wait", bus.timeout, exp_to);
        bus.loss_clr = 1'b1;
        tick(1);
        bus.loss_clr = 1'b0;
        tick(2);
        chk("timeout_clr", bus.timeout, 0);

        // Asynchronous reset mid-STABILIZE
        bus.locked = 1'b1;
        tick(8);
        chk("async_pre_stab", bus.state, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_stab_state", bus.state, 0);
        chk("async_stab_rst_n", bus.pll_rst_n, 0);
        tick(1);
        reset_n = 1'b1;
        wait_run(n);

        // Asynchronous reset mid-LOST
        bus.locked = 1'b0;
        tick(5);
        chk("async_pre_lost", bus.state, 3);
        chk("async_pre_count", bus.loss_count, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_lost_state", bus.state, 0);
        chk("async_lost_count", bus.loss_count, 0);
        chk("async_lost_ready", bus.ready, 0);
        tick(2);
        reset_n = 1'b1;
        tick(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
